lcd_status_driver: RTL and testbench
====================================

# lcd_status_driver

Consumes the 16-bit status code produced by the process manager and renders it as text on a 16x2 HD44780-compatible character LCD in 8-bit write-only mode. It runs the LCD power-up init sequence, then rewrites both lines whenever the code changes. It has no handshake with the process manager: the code is level-sampled, and only the most recent value is ever displayed.

## Interface
- ENABLE_CYCLES, 12, clk cycles `lcd_en` is held high per byte.
- SETTLE_CYCLES, 2500, clk cycles `lcd_en` is held low after each normal byte.
- CLEAR_CYCLES, 100000, clk cycles `lcd_en` is held low after the clear command (0x01).
- INIT_WAIT_CYCLES, 1000000, idle clk cycles after reset before the first command.
- clk input 1: system clock; all logic is on the rising edge.
- reset input 1: reset, synchronous, active-high.
- code input 16: status code from the process manager.
- lcd_data output 8: LCD DB7..DB0.
- lcd_rs output 1: 0 = command, 1 = character data.
- lcd_rw output 1: tied to 0.
- lcd_en output 1: LCD enable strobe.
- lcd_on output 1: LCD power/backlight enable; 1 whenever reset is low.
- busy output 1: high during init or a refresh.
- shown_code output 16: code currently on the display; 0xFFFF until the first refresh completes.

## Operation
- States: INIT_WAIT -> INIT_CMD -> IDLE -> REFRESH -> IDLE.
- INIT_WAIT counts INIT_WAIT_CYCLES with `lcd_en` = 0.
- INIT_CMD issues commands 0x38, 0x0C, 0x06, then 0x01. The clear command uses CLEAR_CYCLES as its settle time.
- IDLE:
  - If `code` != `shown_code`, latch `code` into `pend` and enter REFRESH.
  - Otherwise remain in IDLE with `busy` = 0.
- REFRESH sends 34 bytes in this order:
  - command 0x80;
  - 16 line-1 characters;
  - command 0xC0;
  - 16 line-2 characters.
  - On completion: `shown_code` <= `pend`, then return to IDLE.
- Line-1 text, space-padded to 16 characters and chosen by `pend`:
  - 0 "AGUARDANDO"
  - 1..10 "PROCESSO n" (n in decimal, 1-2 digits)
  - 11 "ENTRADA"
  - 12 "TROCA CONTEXTO"
  - 13 "SAIDA"
  - 14 "FIM SO"
  - 15 "SO EXECUTANDO"
  - 16 "FIM PROCESSO"
  - any other value "CODIGO INVALIDO"
- Line 2 is set by the configuration macro (see Configuration).
- `code` changes during REFRESH are ignored. The comparison happens again in IDLE, so intermediate codes are dropped.
- Reset values: `lcd_data` 0x00, `lcd_rs` 0, `lcd_rw` 0, `lcd_en` 0, `lcd_on` 0 (while reset is asserted), `busy` 1, `shown_code` 0xFFFF, state INIT_WAIT.
- Reset asserted mid-byte or mid-refresh: on the next edge `lcd_en` = 0 and the state returns to INIT_WAIT. The full init sequence is repeated.

## Timing
- Byte transaction, one setup cycle plus two phases:
  - setup: `lcd_rs` and `lcd_data` driven, `lcd_en` = 0;
  - ENABLE_CYCLES with `lcd_en` = 1;
  - settle (SETTLE_CYCLES or CLEAR_CYCLES) with `lcd_en` = 0.
- `lcd_rs` and `lcd_data` are stable from the setup cycle through the end of settle.
- Normal byte cost B = 1 + ENABLE_CYCLES + SETTLE_CYCLES.
- Clear byte cost = 1 + ENABLE_CYCLES + CLEAR_CYCLES.
- Init completes INIT_WAIT_CYCLES + 3B + (1 + ENABLE_CYCLES + CLEAR_CYCLES) cycles after reset deasserts. `busy` falls on that edge.
- Refresh latency:
  - IDLE detects the mismatch on one edge.
  - The first setup cycle is the next edge.
  - The refresh lasts 34B cycles.
  - `shown_code` and `busy` update on the same edge in which the last settle ends.
- Back-to-back refreshes have one IDLE cycle between them.
- `code` is launched on the negative edge by the process manager, so a half cycle of setup is guaranteed. No synchroniser is needed.

## Configuration
- LCD_LINE2_CODE_EN defined: line 2 shows "COD: nn".
  - nn is `pend` in two decimal digits (tens = `pend` >= 10).
  - Codes above 16 show "COD: --".
  - The text is space-padded to 16 characters.
- LCD_LINE2_CODE_EN undefined: line 2 is 16 spaces (0x20). Byte count and timing are unchanged.

## Test plan
All scenarios use ENABLE_CYCLES=2, SETTLE_CYCLES=3, CLEAR_CYCLES=20, INIT_WAIT_CYCLES=10, giving B=6.

- Reset released with `code`=0: bytes 0x38, 0x0C, 0x06, 0x01 with `lcd_rs`=0. The first refresh begins at cycle 52 and `busy`=0 after 204 further cycles.
- After the previous scenario, with `code`=0 (the value it refreshed to), set `code`=3: line 1 bytes are "PROCESSO 3" followed by 6 spaces. `shown_code`=3 exactly 1+204 cycles later.
- `code`=12, then change to 13 and then 14 during the refresh: exactly two refreshes occur (12, then 14). `shown_code` ends at 14.
- `code`=40 with macro defined: line 1 "CODIGO INVALIDO " and line 2 "COD: --". With the macro undefined, line 2 is all 0x20.
- Reset asserted mid-refresh while `lcd_en`=1: `lcd_en`=0 next cycle, `shown_code`=0xFFFF, and the init command sequence restarts after 10 idle cycles.
- Every `lcd_en` high pulse is exactly 2 cycles with `lcd_data` stable from 1 cycle before the rising edge until the next setup. `lcd_rw` is never 1.

Source files
------------

// File: rtl/lcd_status_driver_if.sv
// lcd_status_driver_if
//   Pin bundle between the status driver and an HD44780-compatible LCD
//   running in 8-bit write-only mode.
//   lcd_data : DB7..DB0
//   lcd_rs   : 0 = command, 1 = character data
//   lcd_rw   : read/write select (always write)
//   lcd_en   : enable strobe
//   lcd_on   : panel power / backlight enable
//   master modport = the driver, slave modport = the panel side.
interface lcd_status_driver_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en, output lcd_on);
  modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_on);
endinterface

// File: rtl/lcd_status_driver.sv
// lcd_status_driver
//   Renders the 16-bit process-manager status code as text on a 16x2
//   HD44780 LCD. After reset it waits, sends the init commands
//   (0x38, 0x0C, 0x06, 0x01), then rewrites both lines whenever the
//   level-sampled `code` differs from the code currently displayed.
//   Ports:
//     clk        : system clock, rising edge
//     reset      : synchronous, active-high
//     code       : status code (launched on the falling edge upstream)
//     lcd        : LCD pin bundle (master modport)
//     busy       : high during init or a refresh
//     shown_code : code on the display, 0xFFFF before the first refresh
//   Build option:
//     LCD_LINE2_CODE_EN : when defined, line 2 shows "COD: nn" (or
//                         "COD: --" above 16); otherwise 16 spaces.
module lcd_status_driver #(
  parameter int ENABLE_CYCLES    = 12,
  parameter int SETTLE_CYCLES    = 2500,
  parameter int CLEAR_CYCLES     = 100000,
  parameter int INIT_WAIT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                code,
  lcd_status_driver_if.master        lcd,
  output logic                       busy,
  output logic [15:0]                shown_code
);

  typedef enum logic [1:0] {ST_INIT_WAIT, ST_INIT_CMD, ST_IDLE, ST_REFRESH} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_ENABLE, PH_SETTLE} phase_t;

  localparam logic [31:0] INIT_LAST   = 32'(INIT_WAIT_CYCLES - 1);
  localparam logic [31:0] ENABLE_LAST = 32'(ENABLE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] CLEAR_LAST  = 32'(CLEAR_CYCLES - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;     // byte index within init (0..3) or refresh (0..33)
  logic [15:0] pend_q, pend_d;
  logic [15:0] shown_q, shown_d;

  logic        last_byte;
  logic [31:0] settle_last;
  logic        active;
  logic [3:0]  col1, col2;
  logic [7:0]  cur_byte;

  // Left-justify a right-aligned string literal, filling with spaces.
  function automatic logic [127:0] pad16(input logic [127:0] s);
    logic [127:0] t;
    t = s;
    for (int i = 0; i < 16; i++) begin
      if (t[127:120] == 8'h00) t = {t[119:0], 8'h20};
    end
    return t;
  endfunction

  function automatic logic [7:0] line1_char(input logic [15:0] p, input logic [3:0] col);
    logic [127:0] text;
    case (p)
      16'd0:  text = pad16(128'("AGUARDANDO"));
      16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
      16'd6, 16'd7, 16'd8, 16'd9, 16'd10: begin
        text = pad16(128'("PROCESSO"));
        if (p == 16'd10) begin
          text[55:48] = "1";
          text[47:40] = "0";
        end else begin
          text[55:48] = 8'h30 + p[7:0];
        end
      end
      16'd11: text = pad16(128'("ENTRADA"));
      16'd12: text = pad16(128'("TROCA CONTEXTO"));
      16'd13: text = pad16(128'("SAIDA"));
      16'd14: text = pad16(128'("FIM SO"));
      16'd15: text = pad16(128'("SO EXECUTANDO"));
      16'd16: text = pad16(128'("FIM PROCESSO"));
      default: text = pad16(128'("CODIGO INVALIDO"));
    endcase
    return text[{4'd15 - col, 3'b000} +: 8];
  endfunction

`ifdef LCD_LINE2_CODE_EN
  function automatic logic [7:0] line2_char(input logic [15:0] p, input logic [3:0] col);
    logic [127:0] text;
    text = pad16(128'("COD: --"));
    if (p <= 16'd16) begin
      text[87:80] = (p >= 16'd10) ? 8'h31 : 8'h30;
      text[79:72] = 8'h30 + ((p >= 16'd10) ? (p[7:0] - 8'd10) : p[7:0]);
    end
    return text[{4'd15 - col, 3'b000} +: 8];
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT_WAIT;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      shown_q <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    shown_d     = shown_q;
    last_byte   = (state_q == ST_INIT_CMD) ? (idx_q == 6'd3) : (idx_q == 6'd33);
    // Only the clear command (last init byte) gets the long settle time.
    settle_last = (state_q == ST_INIT_CMD && idx_q == 6'd3) ? CLEAR_LAST : SETTLE_LAST;
    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_INIT_CMD;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (code != shown_q) begin
          pend_d  = code;
          state_d = ST_REFRESH;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_ENABLE;
            cnt_d   = '0;
          end
          PH_ENABLE: begin
            if (cnt_q == ENABLE_LAST) begin
              phase_d = PH_SETTLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          default: begin
            if (cnt_q == settle_last) begin
              cnt_d   = '0;
              phase_d = PH_SETUP;
              if (last_byte) begin
                state_d = ST_IDLE;
                if (state_q == ST_REFRESH) shown_d = pend_q;
              end else begin
                idx_d = idx_q + 6'd1;
              end
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        endcase
      end
    endcase
  end

  // Output logic
  always_comb begin
    active   = (state_q == ST_INIT_CMD) || (state_q == ST_REFRESH);
    col1     = 4'(idx_q - 6'd1);
    col2     = 4'(idx_q - 6'd18);
    cur_byte = 8'h00;
    if (state_q == ST_INIT_CMD) begin
      case (idx_q[1:0])
        2'd0:    cur_byte = 8'h38;
        2'd1:    cur_byte = 8'h0C;
        2'd2:    cur_byte = 8'h06;
        default: cur_byte = 8'h01;
      endcase
    end else if (state_q == ST_REFRESH) begin
      if (idx_q == 6'd0)       cur_byte = 8'h80;
      else if (idx_q <= 6'd16) cur_byte = line1_char(pend_q, col1);
      else if (idx_q == 6'd17) cur_byte = 8'hC0;
      else begin
`ifdef LCD_LINE2_CODE_EN
        cur_byte = line2_char(pend_q, col2);
`else
        cur_byte = 8'h20;
`endif
      end
    end
    lcd.lcd_data = active ? cur_byte : 8'h00;
    lcd.lcd_rs   = (state_q == ST_REFRESH) && (idx_q != 6'd0) && (idx_q != 6'd17);
    lcd.lcd_rw   = 1'b0;
    lcd.lcd_en   = active && (phase_q == PH_ENABLE);
    lcd.lcd_on   = ~reset;
    busy         = (state_q != ST_IDLE);
    shown_code   = shown_q;
  end

endmodule

// File: tb/tb_lcd_status_driver.sv
// tb_lcd_status_driver
//   Scoreboard bench for lcd_status_driver with short timing parameters
//   (ENABLE=2, SETTLE=3, CLEAR=20, INIT_WAIT=10, so one byte = 6 cycles).
//   Stimulus pushes expected LCD bytes and shown_code updates into queues;
//   a monitor pops and compares on every lcd_en rising edge / shown_code
//   change, and also checks strobe width and bus stability.
module tb_lcd_status_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] code = 16'd0;
  logic        busy;
  logic [15:0] shown_code;

  lcd_status_driver_if lcd_bus ();

  lcd_status_driver #(
    .ENABLE_CYCLES   (2),
    .SETTLE_CYCLES   (3),
    .CLEAR_CYCLES    (20),
    .INIT_WAIT_CYCLES(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .code      (code),
    .lcd       (lcd_bus),
    .busy      (busy),
    .shown_code(shown_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic [8:0]  exp_q[$];
  logic [15:0] sh_q[$];

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string line1_text(input int p);
    if (p == 0) return "AGUARDANDO";
    if (p >= 1 && p <= 10) return $sformatf("PROCESSO %0d", p);
    if (p == 11) return "ENTRADA";
    if (p == 12) return "TROCA CONTEXTO";
    if (p == 13) return "SAIDA";
    if (p == 14) return "FIM SO";
    if (p == 15) return "SO EXECUTANDO";
    if (p == 16) return "FIM PROCESSO";
    return "CODIGO INVALIDO";
  endfunction

  function automatic string line2_text(input int p);
`ifdef LCD_LINE2_CODE_EN
    if (p > 16) return "COD: --";
    return $sformatf("COD: %02d", p);
`else
    return "";
`endif
  endfunction

  function automatic logic [7:0] text_char(input string s, input int i);
    if (i < s.len()) return s[i];
    return 8'h20;
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_refresh(input int p);
    string l1, l2;
    l1 = line1_text(p);
    l2 = line2_text(p);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, text_char(l1, i)});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, text_char(l2, i)});
    sh_q.push_back(16'(p));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev_en;
    logic [8:0] prev_bus, held, cur, e;
    logic [15:0] prev_shown;
    int width;
    prev_en = 1'b0; prev_bus = '0; held = '0; width = 0; prev_shown = 16'hFFFF;
    forever begin
      @(negedge clk);
      cur = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
      if (reset) begin
        prev_en = 1'b0;
        width = 0;
        prev_shown = shown_code;
      end else begin
        check("rw_low", 32'(lcd_bus.lcd_rw), 32'd0);
        if (lcd_bus.lcd_en && !prev_en) begin
          check("setup_stable", 32'(cur), 32'(prev_bus));
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte: got rs=%0d data=0x%02h, expected none", cur[8], cur[7:0]);
          end else begin
            e = exp_q.pop_front();
            check("lcd_byte", 32'(cur), 32'(e));
          end
          $display("byte @%0d rs=%0d data=0x%02h", cyc, cur[8], cur[7:0]);
          held = cur;
          width = 1;
        end else if (lcd_bus.lcd_en) begin
          width++;
          check("en_hold", 32'(cur), 32'(held));
        end else if (prev_en) begin
          check("en_width", 32'(width), 32'd2);
        end
        if (shown_code !== prev_shown) begin
          if (sh_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_shown: got 0x%04h, expected none", shown_code);
          end else begin
            check("shown_code", 32'(shown_code), 32'(sh_q.pop_front()));
          end
          $display("shown @%0d code=0x%04h", cyc, shown_code);
          prev_shown = shown_code;
        end
        prev_en = lcd_bus.lcd_en;
        prev_bus = cur;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_busy(input logic lvl, input int budget, input string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (busy === lvl) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: busy never reached %0d within %0d cycles", name, lvl, budget);
    end
  endtask

  task automatic wait_en_rise(input int budget, input string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (lcd_bus.lcd_en === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: lcd_en never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic run_init_and_first_refresh(input string tag);
    int t;
    wait_en_rise(40, {tag, "_first_en"}, t);
    check({tag, "_first_en_cycle"}, 32'(t), 32'd11);
    wait_busy(1'b0, 100, {tag, "_init_done"}, t);
    check({tag, "_init_done_cycle"}, 32'(t), 32'd51);
    wait_busy(1'b1, 5, {tag, "_refresh_start"}, t);
    check({tag, "_refresh_start_cycle"}, 32'(t), 32'd52);
    wait_busy(1'b0, 300, {tag, "_refresh_done"}, t);
    check({tag, "_refresh_done_cycle"}, 32'(t), 32'd256);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t0, n, c, model_shown;
    reset = 1'b1;
    code = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_shown", 32'(shown_code), 32'hFFFF);
    check("rst_en", 32'(lcd_bus.lcd_en), 32'd0);
    check("rst_data", 32'(lcd_bus.lcd_data), 32'd0);
    check("rst_rs", 32'(lcd_bus.lcd_rs), 32'd0);
    check("rst_on", 32'(lcd_bus.lcd_on), 32'd0);

    // Power-up init, then refresh to code 0
    push_init();
    push_refresh(0);
    model_shown = 0;
    reset = 1'b0;
    run_init_and_first_refresh("boot");
    check("lcd_on_run", 32'(lcd_bus.lcd_on), 32'd1);
    check("boot_shown", 32'(shown_code), 32'd0);

    // Single change to 3: latency 1 + 34B
    repeat (2) @(negedge clk);
    t0 = cyc;
    code = 16'd3;
    push_refresh(3);
    model_shown = 3;
    n = 0;
    while (shown_code !== 16'd3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("code3_latency", 32'(cyc), 32'(t0 + 205));
    check("code3_busy_low", 32'(busy), 32'd0);

    // 12, then 13 and 14 during the refresh: only 12 and 14 are shown
    @(negedge clk);
    code = 16'd12;
    push_refresh(12);
    wait_busy(1'b1, 5, "r12_start", t);
    repeat (40) @(negedge clk);
    code = 16'd13;
    repeat (40) @(negedge clk);
    code = 16'd14;
    push_refresh(14);
    wait_busy(1'b0, 300, "r12_done", t0);
    check("r12_shown", 32'(shown_code), 32'd12);
    wait_busy(1'b1, 5, "r14_start", t);
    check("back_to_back_gap", 32'(t), 32'(t0 + 1));
    wait_busy(1'b0, 300, "r14_done", t);
    check("r14_shown", 32'(shown_code), 32'd14);
    model_shown = 14;

    // Out-of-range code
    @(negedge clk);
    code = 16'd40;
    push_refresh(40);
    model_shown = 40;
    wait_busy(1'b1, 5, "r40_start", t);
    wait_busy(1'b0, 300, "r40_done", t);
    check("r40_shown", 32'(shown_code), 32'd40);

    // Randomized codes, one at a time
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      c = $urandom_range(0, 40);
      code = 16'(c);
      if (c != model_shown) begin
        push_refresh(c);
        model_shown = c;
        wait_busy(1'b1, 5, "rand_start", t);
        wait_busy(1'b0, 300, "rand_done", t);
        check("rand_shown", 32'(shown_code), 32'(c));
      end else begin
        repeat (2) @(negedge clk);
        check("rand_no_refresh", 32'(busy), 32'd0);
      end
    end

    // Reset in the middle of a refresh, while lcd_en is high
    @(negedge clk);
    c = (model_shown == 7) ? 9 : 7;
    code = 16'(c);
    push_refresh(c);
    wait_busy(1'b1, 5, "abort_start", t);
    repeat ($urandom_range(20, 150)) @(negedge clk);
    wait_en_rise(20, "abort_en", t);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_en_low", 32'(lcd_bus.lcd_en), 32'd0);
    check("abort_shown", 32'(shown_code), 32'hFFFF);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_on", 32'(lcd_bus.lcd_on), 32'd0);
    exp_q.delete();
    sh_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    push_refresh(c);
    model_shown = c;
    reset = 1'b0;
    run_init_and_first_refresh("reboot");
    check("reboot_shown", 32'(shown_code), 32'(c));

    // Drain and confirm nothing expected was left unseen
    repeat (5) @(negedge clk);
    check("bytes_drained", 32'(exp_q.size()), 32'd0);
    check("shown_drained", 32'(sh_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule
